// File: rtl/iddr_delay_calib.sv
// iddr_delay_calib - input-delay training controller for the IDELAY/IDDR
// capture stage.
//
// Sweeps the shared delay tap from 0 to MAX_TAP while a fixed training
// pattern is received. Each tap is checked over SAMPLE_COUNT cycles. The
// longest contiguous run of passing taps is tracked, and its centre is loaded
// as the final tap. If no run reaches MIN_WINDOW, DEFAULT_TAP is loaded and
// fail is raised instead of done.
//
// Optional build macro:
//   IDDR_CALIB_READBACK_EN - on the last settle cycle of every tap, compare
//   each lane's tap readback with the loaded value. A mismatch aborts the
//   sweep and takes the fail path. When the macro is undefined, cnt_value_out
//   is ignored.
//
// Ports:
//   clk            capture clock (same clock as the IDDR stage)
//   rst            synchronous active-high reset
//   start          one-cycle pulse; begins calibration when idle
//   q1, q2         IDDR rising/falling-edge outputs, WIDTH lanes
//   cnt_value_out  tap readback, 9 bits per lane
//   dly_load       one-cycle pulse loading dly_cnt_value into the delay line
//   dly_cnt_value  tap value to load (held between loads)
//   dly_en_vtc     VT compensation enable (low while sweeping)
//   busy           calibration in progress
//   done, fail     sticky result flags
//   tap            final loaded tap
//   window_len     best passing window length
module iddr_delay_calib #(
  parameter int               WIDTH         = 1,
  parameter logic [WIDTH-1:0] EXPECT_Q1     = {WIDTH{1'b1}},
  parameter logic [WIDTH-1:0] EXPECT_Q2     = {WIDTH{1'b0}},
  parameter int               MAX_TAP       = 511,
  parameter int               SETTLE_CYCLES = 8,
  parameter int               SAMPLE_COUNT  = 64,
  parameter int               MIN_WINDOW    = 4,
  parameter int               DEFAULT_TAP   = 25
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   q1,
  input  logic [WIDTH-1:0]   q2,
  input  logic [WIDTH*9-1:0] cnt_value_out,
  output logic               dly_load,
  output logic [8:0]         dly_cnt_value,
  output logic               dly_en_vtc,
  output logic               busy,
  output logic               done,
  output logic               fail,
  output logic [8:0]         tap,
  output logic [9:0]         window_len
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_SETTLE = 3'd2,
    S_SAMPLE = 3'd3,
    S_EVAL   = 3'd4,
    S_FINAL  = 3'd5,
    S_DONE   = 3'd6
  } state_t;

  state_t      state_r;
  logic [8:0]  cur_tap_r;
  logic [15:0] cnt_r;
  logic        pass_r;
  logic [9:0]  run_start_r;
  logic [9:0]  run_len_r;
  logic [9:0]  best_start_r;
  logic [9:0]  best_len_r;
  logic        rb_err_r;
  logic        res_ok_r;

  logic        lane_match_s;
  logic        rb_mismatch_s;
  logic [9:0]  fin_start_s;
  logic [9:0]  fin_len_s;
  logic [9:0]  mid_s;
  logic        res_ok_s;
  logic [8:0]  res_tap_s;
  logic [9:0]  res_len_s;

  // Every lane must match its expected pattern in the same cycle.
  assign lane_match_s = (q1 == EXPECT_Q1) && (q2 == EXPECT_Q2);

`ifdef IDDR_CALIB_READBACK_EN
  // Returns 1 when any lane's 9-bit readback differs from the loaded tap.
  function automatic logic rb_mismatch(input logic [WIDTH*9-1:0] rb,
                                       input logic [8:0]         val);
    logic mis;
    mis = 1'b0;
    for (int l = 0; l < WIDTH; l++) begin
      if (rb[l*9 +: 9] != val) begin
        mis = 1'b1;
      end else begin
        mis = mis;
      end
    end
    return mis;
  endfunction

  assign rb_mismatch_s = rb_mismatch(cnt_value_out, dly_cnt_value);
`else
  logic unused_rb_s;
  assign unused_rb_s   = ^cnt_value_out;
  assign rb_mismatch_s = 1'b0;
`endif

  // Final result: close any run still open at MAX_TAP, then pick centre or default.
  always_comb begin
    fin_start_s = best_start_r;
    fin_len_s   = best_len_r;
    res_ok_s    = 1'b0;
    res_len_s   = 10'd0;
    res_tap_s   = 9'(DEFAULT_TAP);
    if (run_len_r > best_len_r) begin
      fin_start_s = run_start_r;
      fin_len_s   = run_len_r;
    end else begin
      fin_start_s = best_start_r;
      fin_len_s   = best_len_r;
    end
    // Truncating centre; only meaningful when fin_len_s is non-zero.
    mid_s = fin_start_s + ((fin_len_s - 10'd1) >> 1);
    if (rb_err_r) begin
      res_ok_s  = 1'b0;
      res_len_s = 10'd0;
    end else begin
      res_ok_s  = (fin_len_s >= 10'(MIN_WINDOW));
      res_len_s = fin_len_s;
    end
    if (res_ok_s) begin
      res_tap_s = mid_s[8:0];
    end else begin
      res_tap_s = 9'(DEFAULT_TAP);
    end
  end

  // Calibration state machine with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= S_IDLE;
      dly_load      <= 1'b0;
      dly_cnt_value <= 9'd0;
      dly_en_vtc    <= 1'b1;
      busy          <= 1'b0;
      done          <= 1'b0;
      fail          <= 1'b0;
      tap           <= 9'd0;
      window_len    <= 10'd0;
      cur_tap_r     <= 9'd0;
      cnt_r         <= 16'd0;
      pass_r        <= 1'b0;
      run_start_r   <= 10'd0;
      run_len_r     <= 10'd0;
      best_start_r  <= 10'd0;
      best_len_r    <= 10'd0;
      rb_err_r      <= 1'b0;
      res_ok_r      <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          dly_load <= 1'b0;
          if (start) begin
            busy         <= 1'b1;
            done         <= 1'b0;
            fail         <= 1'b0;
            dly_en_vtc   <= 1'b0;
            cur_tap_r    <= 9'd0;
            run_start_r  <= 10'd0;
            run_len_r    <= 10'd0;
            best_start_r <= 10'd0;
            best_len_r   <= 10'd0;
            rb_err_r     <= 1'b0;
            state_r      <= S_LOAD;
          end else begin
            state_r <= S_IDLE;
          end
        end
        S_LOAD: begin
          // The pulse is visible during the first settle cycle.
          dly_load      <= 1'b1;
          dly_cnt_value <= cur_tap_r;
          cnt_r         <= 16'd0;
          state_r       <= S_SETTLE;
        end
        S_SETTLE: begin
          dly_load <= 1'b0;
          if (cnt_r == 16'(SETTLE_CYCLES - 1)) begin
            cnt_r  <= 16'd0;
            pass_r <= 1'b1;
            if (rb_mismatch_s) begin
              rb_err_r <= 1'b1;
              state_r  <= S_FINAL;
            end else begin
              state_r <= S_SAMPLE;
            end
          end else begin
            cnt_r <= cnt_r + 16'd1;
          end
        end
        S_SAMPLE: begin
          if (!lane_match_s) begin
            pass_r <= 1'b0;
          end else begin
            pass_r <= pass_r;
          end
          if (cnt_r == 16'(SAMPLE_COUNT - 1)) begin
            cnt_r   <= 16'd0;
            state_r <= S_EVAL;
          end else begin
            cnt_r <= cnt_r + 16'd1;
          end
        end
        S_EVAL: begin
          if (pass_r) begin
            if (run_len_r == 10'd0) begin
              run_start_r <= {1'b0, cur_tap_r};
              run_len_r   <= 10'd1;
            end else begin
              run_len_r <= run_len_r + 10'd1;
            end
          end else begin
            // Strictly greater: earliest window wins ties.
            if (run_len_r > best_len_r) begin
              best_start_r <= run_start_r;
              best_len_r   <= run_len_r;
            end else begin
              best_len_r <= best_len_r;
            end
            run_len_r <= 10'd0;
          end
          if (cur_tap_r == 9'(MAX_TAP)) begin
            state_r <= S_FINAL;
          end else begin
            cur_tap_r <= cur_tap_r + 9'd1;
            state_r   <= S_LOAD;
          end
        end
        S_FINAL: begin
          dly_load      <= 1'b1;
          dly_cnt_value <= res_tap_s;
          tap           <= res_tap_s;
          window_len    <= res_len_s;
          res_ok_r      <= res_ok_s;
          state_r       <= S_DONE;
        end
        S_DONE: begin
          dly_load   <= 1'b0;
          busy       <= 1'b0;
          done       <= res_ok_r;
          fail       <= !res_ok_r;
          dly_en_vtc <= 1'b1;
          state_r    <= S_IDLE;
        end
        default: begin
          dly_load <= 1'b0;
          busy     <= 1'b0;
          state_r  <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iddr_delay_calib.sv
// Scoreboard bench for iddr_delay_calib. A behavioural IDELAY/IDDR model
// follows the loaded tap and produces the training pattern for taps in
// pass_mask. Each sweep pushes its hand-computed result; a monitor pops and
// compares when busy falls.
module tb_iddr_delay_calib;

  localparam int W = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [W-1:0]   q1;
  logic [W-1:0]   q2;
  logic [W*9-1:0] cnt_value_out;
  logic           dly_load;
  logic [8:0]     dly_cnt_value;
  logic           dly_en_vtc;
  logic           busy;
  logic           done;
  logic           fail;
  logic [8:0]     tap;
  logic [9:0]     window_len;

  always #5 clk = ~clk;

  iddr_delay_calib #(
    .WIDTH(W), .MAX_TAP(63), .SETTLE_CYCLES(4), .SAMPLE_COUNT(16),
    .MIN_WINDOW(4), .DEFAULT_TAP(25)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .q1(q1), .q2(q2),
    .cnt_value_out(cnt_value_out), .dly_load(dly_load),
    .dly_cnt_value(dly_cnt_value), .dly_en_vtc(dly_en_vtc), .busy(busy),
    .done(done), .fail(fail), .tap(tap), .window_len(window_len)
  );

  // Delay-line model
  logic [511:0] pass_mask = '0;
  logic         glitch_en = 1'b0;
  logic         rb_fault  = 1'b0;
  logic [8:0]   model_tap = 9'd0;
  logic [8:0]   rb_val;
  int           since_load = 100;

  always @(posedge clk) begin
    if (dly_load) model_tap <= dly_cnt_value;
    since_load <= dly_load ? 1 : since_load + 1;
  end

  always_comb begin
    q1 = '0;
    q2 = {W{1'b1}};
    if (pass_mask[model_tap]) begin
      q1 = {W{1'b1}};
      q2 = '0;
    end
    if (glitch_en && model_tap == 9'd30 && since_load == 10) q2[1] = ~q2[1];
    rb_val = (rb_fault && model_tap == 9'd8) ? 9'd7 : model_tap;
    cnt_value_out = {W{rb_val}};
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    string name;
    int    done;
    int    fail;
    int    tap;
    int    wl;
  } exp_t;

  exp_t sb_q[$];

  // Monitor: on each completed sweep, compare against the oldest expectation.
  logic       prev_busy = 1'b0;
  logic [8:0] last_load = 9'd0;
  always @(negedge clk) begin
    exp_t e;
    if (dly_load) last_load = dly_cnt_value;
    if (prev_busy && !busy && !rst) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_completion", 1, 0);
      end else begin
        e = sb_q.pop_front();
        chk({e.name, ".done"}, int'(done), e.done);
        chk({e.name, ".fail"}, int'(fail), e.fail);
        chk({e.name, ".tap"}, int'(tap), e.tap);
        chk({e.name, ".window_len"}, int'(window_len), e.wl);
        chk({e.name, ".final_load"}, int'(last_load), e.tap);
        chk({e.name, ".en_vtc"}, int'(dly_en_vtc), 1);
      end
    end
    prev_busy = busy;
  end

  task automatic set_window(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) pass_mask[i] = 1'b1;
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic run_sweep(input string name, input int d, input int f,
                           input int t, input int wl, input bit extra_start);
    exp_t e;
    e.name = name; e.done = d; e.fail = f; e.tap = t; e.wl = wl;
    sb_q.push_back(e);
    pulse_start();
    chk({name, ".busy_after_start"}, int'(busy), 1);
    chk({name, ".en_vtc_low"}, int'(dly_en_vtc), 0);
    if (extra_start) begin
      repeat (300) @(negedge clk);
      pulse_start();
    end
    for (int i = 0; i < 3000; i++) begin
      if (sb_q.size() == 0) break;
      @(negedge clk);
    end
    if (sb_q.size() != 0) begin
      chk({name, ".timeout"}, sb_q.size(), 0);
      sb_q.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int loads;
    bit found;
    rst   = 1'b1;
    start = 1'b1;   // start together with rst must be ignored
    repeat (3) @(negedge clk);
    chk("rst.dly_load", int'(dly_load), 0);
    chk("rst.dly_cnt_value", int'(dly_cnt_value), 0);
    chk("rst.dly_en_vtc", int'(dly_en_vtc), 1);
    chk("rst.busy", int'(busy), 0);
    chk("rst.done", int'(done), 0);
    chk("rst.fail", int'(fail), 0);
    chk("rst.tap", int'(tap), 0);
    chk("rst.window_len", int'(window_len), 0);
    start = 1'b0;
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);

    pass_mask = '0; set_window(20, 35);
    run_sweep("win20_35", 1, 0, 27, 16, 1'b0);

    pass_mask = '0; set_window(5, 8); set_window(40, 50);
    run_sweep("two_windows", 1, 0, 45, 11, 1'b1);

    pass_mask = '0; set_window(10, 13); set_window(30, 33);
    run_sweep("tie_earliest", 1, 0, 11, 4, 1'b0);

    pass_mask = '0;
    run_sweep("no_pass", 0, 1, 25, 0, 1'b0);

    pass_mask = '0; set_window(2, 4);
    run_sweep("short_window", 0, 1, 25, 3, 1'b0);

    pass_mask = '0; set_window(58, 63);
    run_sweep("open_at_max", 1, 0, 60, 6, 1'b0);

    pass_mask = '0; set_window(20, 35); glitch_en = 1'b1;
    run_sweep("glitch_tap30", 1, 0, 24, 10, 1'b0);
    glitch_en = 1'b0;

    // Reset during SAMPLE at tap 12
    pass_mask = '0; set_window(20, 35);
    pulse_start();
    found = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (model_tap == 9'd12 && since_load == 10) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("abort.reached_tap12", int'(found), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("abort.busy", int'(busy), 0);
    chk("abort.en_vtc", int'(dly_en_vtc), 1);
    chk("abort.dly_load", int'(dly_load), 0);
    #1 rst = 1'b0;
    loads = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (dly_load || busy) loads++;
    end
    chk("abort.quiet_after_rst", loads, 0);
    run_sweep("after_abort", 1, 0, 27, 16, 1'b0);

`ifdef IDDR_CALIB_READBACK_EN
    rb_fault = 1'b1;
    run_sweep("readback_err", 0, 1, 25, 0, 1'b0);
    rb_fault = 1'b0;
    run_sweep("readback_ok", 1, 0, 27, 16, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/iddr_delay_calib.md
Name: iddr_delay_calib

Overview:
- Input-delay training controller for the IDELAY-based IDDR capture stage.
- Sweeps the shared delay tap across its full range while a known training pattern is received.
- Checks the captured q1/q2 words at each tap, finds the longest contiguous passing window, and loads the window centre as the final tap.
- Sits beside the IDDR capture stage: it drives the IDDR delay-control inputs and consumes the IDDR outputs.

Parameters:
- WIDTH, 1: number of IDDR lanes; must match the capture stage.
- EXPECT_Q1, {WIDTH{1'b1}}: expected q1 value during training.
- EXPECT_Q2, {WIDTH{1'b0}}: expected q2 value during training.
- MAX_TAP, 511: last tap swept; range 1..511.
- SETTLE_CYCLES, 8: wait after each load before sampling; range 1..255.
- SAMPLE_COUNT, 64: compare cycles per tap; range 1..65535.
- MIN_WINDOW, 4: minimum passing window length for success; range 1..512.
- DEFAULT_TAP, 25: tap loaded when calibration fails.

Ports:
- clk  in  1  capture clock, same clock as the IDDR stage
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle pulse; begins calibration when idle
- q1  in  WIDTH  IDDR rising-edge output
- q2  in  WIDTH  IDDR falling-edge output
- cnt_value_out  in  WIDTH*9  tap readback from the IDDR stage
- dly_load  out  1  one-cycle pulse loading dly_cnt_value
- dly_cnt_value  out  9  tap value to load
- dly_en_vtc  out  1  VT compensation enable
- busy  out  1  calibration in progress
- done  out  1  calibration finished and passed (sticky)
- fail  out  1  calibration finished and failed (sticky)
- tap  out  9  final loaded tap
- window_len  out  10  best window length found

Behaviour:
- Reset values: dly_load=0, dly_cnt_value=0, dly_en_vtc=1, busy=0, done=0, fail=0, tap=0, window_len=0. The state machine returns to IDLE.
- Reset mid-sweep aborts immediately: outputs go to reset values on the next edge and no further load pulse is issued.
- Integration requirements:
  - IDELAY instances are in VAR_LOAD mode.
  - IDDR en and inc are tied low; this block only uses LOAD.
- States:
  - IDLE: waits for start. Entering a sweep asserts busy, clears done and fail, drives dly_en_vtc=0, and sets cur_tap=0.
  - LOAD: dly_load=1 for exactly one cycle with dly_cnt_value=cur_tap. dly_cnt_value holds stable until the next LOAD.
  - SETTLE: counts SETTLE_CYCLES cycles.
  - SAMPLE: runs for SAMPLE_COUNT cycles. The tap passes only if q1==EXPECT_Q1 and q2==EXPECT_Q2 on every cycle, all lanes simultaneously.
  - EVAL: one cycle; updates the window tracker.
  - Next step: if cur_tap==MAX_TAP go to FINAL; otherwise cur_tap+1 and go to LOAD.
  - FINAL: computes the result and issues one LOAD pulse with the result tap.
  - DONE: the cycle after FINAL's load; busy=0 and done or fail asserts. Returns to IDLE.
- Window tracker:
  - run_start and run_len are 10-bit.
  - A pass with run_len==0 sets run_start=cur_tap, run_len=1; any other pass increments run_len.
  - A fail closes the run: if run_len > best_len (strictly greater, so the earliest window wins ties), copy run_start/run_len to best_start/best_len; then clear run_len.
  - A run still open at MAX_TAP is closed the same way in FINAL.
- Result:
  - If best_len >= MIN_WINDOW: tap = best_start + ((best_len-1)>>1) (truncating), done=1.
  - Otherwise: tap = DEFAULT_TAP, fail=1.
  - window_len = best_len in both cases.
- dly_en_vtc returns to 1 in the DONE state.
- Per-tap cost: 1 + SETTLE_CYCLES + SAMPLE_COUNT + 1 cycles.
- start while busy is ignored. start in the same cycle as rst is ignored.

Optional Feature:
- IDDR_CALIB_READBACK_EN defined:
  - On the last SETTLE cycle, every lane's 9-bit field of cnt_value_out is compared with dly_cnt_value.
  - Any mismatch aborts to FINAL and forces the fail path: tap=DEFAULT_TAP, fail=1, window_len=0.
- Not defined: cnt_value_out is ignored and no comparator logic is generated.

Test Plan:
- MAX_TAP=63, SETTLE=4, SAMPLE=16; model passes taps 20..35 -> window_len=16, tap=27, done=1, final dly_load pulse with dly_cnt_value=27, dly_en_vtc back to 1.
- Passing windows 5..8 and 40..50 -> window_len=11, tap=45. Equal windows 10..13 and 30..33 -> tap=11 (earliest wins).
- No passing tap -> fail=1, tap=25, window_len=0. Window 2..4 with MIN_WINDOW=4 -> fail=1, window_len=3.
- Window 58..63 open at MAX_TAP -> window_len=6, tap=60. Single-cycle mismatch injected at tap 30 within window 20..35 -> window_len=10, tap=24.
- rst asserted during SAMPLE at tap 12 -> next cycle busy=0, dly_en_vtc=1, no dly_load. A new start then yields the full sweep result.
- With IDDR_CALIB_READBACK_EN: model returns readback 7 when 8 is loaded -> fail=1, tap=25. Matching model reproduces the first scenario.
